cpht_table: RTL and testbench

Choice pattern history table for the tournament branch predictor: an array of 2^INDEX_W two-bit saturating choice counters selecting between predictor 1 and predictor 2. It sits directly upstream of the final prediction mux. At fetch it returns a registered choice for an index. At branch resolution it read-modify-writes the indexed counter from the two predictors' correctness bits, using the same per-entry transition rule as the single-counter choice FSM.

---
 rtl/cpht_table.sv | 87 ++++++++
 tb/tb_cpht_table.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpht_table.sv
// cpht_table: choice pattern history table for the tournament predictor.
// 2^INDEX_W two-bit saturating choice counters held in flops; registered
// lookup port and a read-modify-write update port.
// Encoding: 00 Strongly_p1, 01 Weakly_p1, 10 Weakly_p2, 11 Strongly_p2.
// Build option: define CPHT_BYPASS_EN to forward a same-cycle, same-index
// update into the lookup result (write-first); otherwise lookups are read-first.
module cpht_table #(
  parameter int unsigned INDEX_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_idx,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               p1_res,
  input  logic               p2_res,
  input  logic               clear,
  output logic               pred_valid,
  output logic [1:0]         pred_state,
  output logic               choose_p2
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam logic [1:0]  CTR_MIN = 2'b00;
  localparam logic [1:0]  CTR_MAX = 2'b11;

  logic [1:0] table_q [DEPTH];
  logic [1:0] upd_cur_c;
  logic [1:0] upd_next_c;
  logic [1:0] lookup_data_c;

  // Next value of the entry being updated (saturating inc/dec or hold)
  always_comb begin
    upd_cur_c  = table_q[upd_idx];
    upd_next_c = upd_cur_c;
    unique case ({p1_res, p2_res})
      2'b01:   upd_next_c = (upd_cur_c == CTR_MAX) ? CTR_MAX : upd_cur_c + 2'd1;
      2'b10:   upd_next_c = (upd_cur_c == CTR_MIN) ? CTR_MIN : upd_cur_c - 2'd1;
      default: upd_next_c = upd_cur_c;
    endcase
  end

  // Lookup data: clear forwards 00; same-index update handled per build
  always_comb begin
    lookup_data_c = table_q[lookup_idx];
    if (clear) begin
      lookup_data_c = CTR_MIN;
    end
`ifdef CPHT_BYPASS_EN
    else if (upd_valid && (upd_idx == lookup_idx)) begin
      lookup_data_c = upd_next_c;
    end
`endif
  end

  // Counter array: reset > clear > update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= CTR_MIN;
      end
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= CTR_MIN;
      end
    end else if (upd_valid) begin
      table_q[upd_idx] <= upd_next_c;
    end
  end

  // Registered lookup result; state holds when no lookup is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_state <= CTR_MIN;
      choose_p2  <= 1'b0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_state <= lookup_data_c;
        choose_p2  <= lookup_data_c[1];
      end
    end
  end

endmodule

// File: tb/tb_cpht_table.sv
// Testbench for cpht_table: directed scenarios plus randomized traffic,
// checked against an integer-array model of the choice counters.
// Honours CPHT_BYPASS_EN the same way the design build does.
module tb_cpht_table;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned DEPTH   = 1 << INDEX_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               lookup_valid;
  logic [INDEX_W-1:0] lookup_idx;
  logic               upd_valid;
  logic [INDEX_W-1:0] upd_idx;
  logic               p1_res;
  logic               p2_res;
  logic               clear;
  logic               pred_valid;
  logic [1:0]         pred_state;
  logic               choose_p2;

  int         mdl [DEPTH];
  logic       exp_valid;
  logic [1:0] exp_state;
  int         n_cmp = 0;
  int         n_err = 0;

  cpht_table #(.INDEX_W(INDEX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .p1_res       (p1_res),
    .p2_res       (p2_res),
    .clear        (clear),
    .pred_valid   (pred_valid),
    .pred_state   (pred_state),
    .choose_p2    (choose_p2)
  );

  always #5 clk = ~clk;

  // Choice counter behaviour: move toward whichever predictor alone was right
  function automatic int next_ctr(input int v, input bit p1, input bit p2);
    if (!p1 && p2) return (v >= 3) ? 3 : v + 1;
    if (p1 && !p2) return (v <= 0) ? 0 : v - 1;
    return v;
  endfunction

  // Drive one cycle of requests, advance the model, and land at posedge+1
  task automatic drive(input bit lv, input int li, input bit uv, input int ui,
                       input bit p1, input bit p2, input bit clr);
    int nv;
    lookup_valid = lv;
    lookup_idx   = INDEX_W'(li);
    upd_valid    = uv;
    upd_idx      = INDEX_W'(ui);
    p1_res       = p1;
    p2_res       = p2;
    clear        = clr;
    nv = uv ? next_ctr(mdl[ui], p1, p2) : 0;
    exp_valid = lv;
    if (lv) begin
      if (clr) exp_state = 2'd0;
`ifdef CPHT_BYPASS_EN
      else if (uv && ui == li) exp_state = 2'(nv);
`endif
      else exp_state = 2'(mdl[li]);
    end
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) mdl[k] = 0;
    end else if (uv) begin
      mdl[ui] = nv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (pred_valid !== 1'b0 || pred_state !== 2'b00 || choose_p2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b s=%b c=%b want v=0 s=00 c=0",
               pred_valid, pred_state, choose_p2);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1, 5, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_valid !== 1'b1 || pred_state !== 2'b00 || choose_p2 !== 1'b0) begin
      n_err++;
      $display("FAIL first_lookup: got v=%b s=%b c=%b want v=1 s=00 c=0",
               pred_valid, pred_state, choose_p2);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_valid !== 1'b0 || pred_state !== 2'b00) begin
      n_err++;
      $display("FAIL idle_hold: got v=%b s=%b want v=0 s=00", pred_valid, pred_state);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 5, 0, 1, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b11 || choose_p2 !== 1'b1 || pred_state !== exp_state) begin
      n_err++;
      $display("FAIL inc_to_11: got s=%b c=%b want s=11 c=1 (model %b)",
               pred_state, choose_p2, exp_state);
    end
    drive(0, 0, 1, 5, 0, 1, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b11 || pred_valid !== 1'b1 || pred_state !== exp_state) begin
      n_err++;
      $display("FAIL saturate_11: got v=%b s=%b want v=1 s=11", pred_valid, pred_state);
    end
  endtask

  task automatic test_dec_hold();
    drive(0, 0, 1, 5, 1, 0, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b10 || choose_p2 !== 1'b1 || pred_state !== exp_state) begin
      n_err++;
      $display("FAIL dec_to_10: got s=%b c=%b want s=10 c=1", pred_state, choose_p2);
    end
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 5, 1, 1, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 5, 0, 0, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b10 || pred_state !== exp_state) begin
      n_err++;
      $display("FAIL hold_10: got s=%b want s=10", pred_state);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] want;
    drive(0, 0, 1, 9, 0, 1, 0);
    drive(1, 9, 1, 9, 0, 1, 0);
`ifdef CPHT_BYPASS_EN
    want = 2'b10;
`else
    want = 2'b01;
`endif
    n_cmp++;
    if (pred_state !== want || pred_valid !== 1'b1 || pred_state !== exp_state) begin
      n_err++;
      $display("FAIL same_idx_lookup: got v=%b s=%b want v=1 s=%b", pred_valid, pred_state, want);
    end
    drive(1, 9, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b10 || choose_p2 !== 1'b1) begin
      n_err++;
      $display("FAIL same_idx_followup: got s=%b c=%b want s=10 c=1", pred_state, choose_p2);
    end
    drive(1, 20, 1, 21, 0, 1, 0);
    n_cmp++;
    if (pred_state !== 2'b00 || pred_state !== exp_state) begin
      n_err++;
      $display("FAIL diff_idx_lookup: got s=%b want s=00", pred_state);
    end
    drive(1, 21, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b01 || pred_state !== exp_state) begin
      n_err++;
      $display("FAIL diff_idx_update: got s=%b want s=01", pred_state);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 3, 0, 1, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 7, 0, 1, 0);
    drive(1, 7, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b10) begin
      n_err++;
      $display("FAIL preclear_7: got s=%b want s=10", pred_state);
    end
    drive(1, 7, 1, 3, 0, 1, 1);
    n_cmp++;
    if (pred_state !== 2'b00 || pred_valid !== 1'b1 || choose_p2 !== 1'b0) begin
      n_err++;
      $display("FAIL clear_forward: got v=%b s=%b c=%b want v=1 s=00 c=0",
               pred_valid, pred_state, choose_p2);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_state !== 2'b00 || pred_valid !== 1'b1) begin
        n_err++;
        $display("FAIL clear_entry[%0d]: got v=%b s=%b want v=1 s=00", i, pred_valid, pred_state);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 63) == 0);
      n_cmp++;
      if (pred_valid !== exp_valid || pred_state !== exp_state || choose_p2 !== exp_state[1]) begin
        n_err++;
        $display("FAIL random[%0d]: got v=%b s=%b c=%b want v=%b s=%b c=%b", n,
                 pred_valid, pred_state, choose_p2, exp_valid, exp_state, exp_state[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 2, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 2 + (i % 2), 1, 40, 0, 1, 0);
    drive(1, 2, 0, 0, 0, 0, 0);
    n_cmp++;
    if (pred_state !== 2'b11 || pred_valid !== 1'b1) begin
      n_err++;
      $display("FAIL prereset_stream: got v=%b s=%b want v=1 s=11", pred_valid, pred_state);
    end
    lookup_valid = 1'b1;
    lookup_idx   = INDEX_W'(2);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pred_valid !== 1'b0 || pred_state !== 2'b00 || choose_p2 !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b s=%b c=%b want v=0 s=00 c=0",
               pred_valid, pred_state, choose_p2);
    end
    for (int k = 0; k < DEPTH; k++) mdl[k] = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pred_valid !== 1'b0 || pred_state !== 2'b00) begin
      n_err++;
      $display("FAIL reset_held: got v=%b s=%b want v=0 s=00", pred_valid, pred_state);
    end
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_state !== 2'b00 || pred_valid !== 1'b1) begin
        n_err++;
        $display("FAIL reset_entry[%0d]: got v=%b s=%b want v=1 s=00", i, pred_valid, pred_state);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    lookup_valid = 1'b0;
    lookup_idx   = '0;
    upd_valid    = 1'b0;
    upd_idx      = '0;
    p1_res       = 1'b0;
    p2_res       = 1'b0;
    clear        = 1'b0;
    exp_valid    = 1'b0;
    exp_state    = 2'b00;
    for (int k = 0; k < DEPTH; k++) mdl[k] = 0;
    test_reset();
    test_saturate();
    test_dec_hold();
    test_same_cycle();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
